// File: rtl/csidh_pkg.sv
// Purpose : shared constants, state encoding and word-count helper for the CSIDH job arbiter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package csidh_pkg;

    localparam int WORD_W      = 64;
    // Default CSIDH-512 operand sizes.
    localparam int CSIDH_N     = 512;
    localparam int CSIDH_KEY_W = 296;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_K,
        RUN,
        DRAIN
    } state_t;

    // Number of 64-bit link words needed to carry a field of the given width.
    function automatic int words_of(input int width);
        return (width + WORD_W - 1) / WORD_W;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : combinational round-robin pick; first set request at or after the pointer, wrapping.
// Latency : combinational, zero cycles.
// Backpressure: none; the parent decides when the pick is consumed.
//
// Ports:
//   i_req  - request vector
//   i_ptr  - round-robin start index (kept below NUM_REQ by the parent)
//   o_any  - at least one request is set
//   o_gnt  - one-hot grant of the picked requester
//   o_idx  - binary index of the picked requester
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic               o_any,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx
);

    logic w_found;

    function automatic int wrap(input int v);
        return v % NUM_REQ;
    endfunction

    always_comb begin
        w_found = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[wrap(int'(i_ptr) + i)]) begin
                w_found = 1'b1;
                o_idx   = IW'(wrap(int'(i_ptr) + i));
            end
        end
    end

    assign o_any = w_found;
    assign o_gnt = w_found ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/csidh_job_arbiter.sv
// Purpose : shares one CSIDH group-action core between NUM_REQ requesters, loading A and the key, returning A_out.
// Latency : grant 1 cycle after req; first result word = core compute time + 2 cycles after the last key word.
// Backpressure: in_valid stalls stretch the load phases; out_ready stalls hold out_data stable.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   req / gnt          - per-requester job request (level) / one-hot grant held for the whole job
//   in_data/valid/ready- per-requester 64-bit input link, only the granted requester sees ready
//   out_*              - 64-bit result stream tagged with out_id, out_last, out_invalid, out_error
//   core_*             - core reset, operands, result, done and invalid flag
//   busy               - high whenever a job is in progress
// Optional feature: define CSIDH_TIMEOUT_EN to build a RUN-phase watchdog (TIMEOUT_CYCLES).
module csidh_job_arbiter
    import csidh_pkg::*;
#(
    parameter int N       = CSIDH_N,
    parameter int KEY_W   = CSIDH_KEY_W,
    parameter int NUM_REQ = 2
`ifdef CSIDH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2**26
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic [64*NUM_REQ-1:0]        in_data,
    input  logic [NUM_REQ-1:0]           in_valid,
    output logic [NUM_REQ-1:0]           in_ready,
    output logic [63:0]                  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_REQ)-1:0]   out_id,
    output logic                         out_last,
    output logic                         out_invalid,
    output logic                         out_error,
    output logic                         core_rst,
    output logic [N-1:0]                 core_A_in,
    output logic [KEY_W-1:0]             core_private,
    input  logic [N-1:0]                 core_A_out,
    input  logic                         core_done,
    input  logic                         core_invalid,
    output logic                         busy
);

    localparam int WA    = words_of(N);
    localparam int WK    = words_of(KEY_W);
    localparam int WMAX  = (WA > WK) ? WA : WK;
    localparam int CNT_W = (WMAX > 1) ? $clog2(WMAX) : 1;
    localparam int IW    = $clog2(NUM_REQ);

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        r_ptr;
    logic [CNT_W-1:0]     r_wcnt;
    logic [N-1:0]         r_a;
    logic [KEY_W-1:0]     r_key;
    logic [N-1:0]         r_res;
    logic                 r_out_valid;
    logic                 r_out_invalid;
    logic                 r_core_rst;
    logic                 r_first;

    logic                 w_any;
    logic [NUM_REQ-1:0]   w_pick_gnt;
    logic [IW-1:0]        w_pick_idx;
    logic                 w_load;
    logic                 w_xfer;
    logic                 w_out_xfer;
    logic [WORD_W-1:0]    w_word;
    logic                 w_last_a;
    logic                 w_last_k;
    logic                 w_last_o;
    logic [IW-1:0]        w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx)
    );

    assign w_load     = (r_state == LOAD_A) || (r_state == LOAD_K);
    assign w_xfer     = w_load && in_valid[r_idx];
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_word     = in_data[int'(r_idx)*WORD_W +: WORD_W];
    assign w_last_a   = (r_wcnt == CNT_W'(WA - 1));
    assign w_last_k   = (r_wcnt == CNT_W'(WK - 1));
    assign w_last_o   = (r_wcnt == CNT_W'(WA - 1));
    assign w_ptr_next = (int'(r_idx) == NUM_REQ - 1) ? '0 : r_idx + 1'b1;

`ifdef CSIDH_TIMEOUT_EN
    logic        r_out_error;
    logic [26:0] r_tmo;
    assign out_error = r_out_error;
`else
    assign out_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_idx         <= '0;
            r_ptr         <= '0;
            r_wcnt        <= '0;
            r_a           <= '0;
            r_key         <= '0;
            r_res         <= '0;
            r_out_valid   <= 1'b0;
            r_out_invalid <= 1'b0;
            r_core_rst    <= 1'b1;
            r_first       <= 1'b0;
`ifdef CSIDH_TIMEOUT_EN
            r_out_error   <= 1'b0;
            r_tmo         <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt         <= w_pick_gnt;
                        r_idx         <= w_pick_idx;
                        r_wcnt        <= '0;
                        r_out_invalid <= 1'b0;
                        r_state       <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (w_xfer) begin
                        r_a[int'(r_wcnt)*WORD_W +: WORD_W] <= w_word;
                        if (w_last_a) begin
                            r_wcnt  <= '0;
                            r_state <= LOAD_K;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                LOAD_K: begin
                    if (w_xfer) begin
                        // Bit-wise placement so the top word's bits above KEY_W simply fall away.
                        for (int b = 0; b < KEY_W; b++) begin
                            if (b / WORD_W == int'(r_wcnt)) begin
                                r_key[b] <= w_word[b % WORD_W];
                            end
                        end
                        if (w_last_k) begin
                            r_wcnt     <= '0;
                            r_core_rst <= 1'b0;
                            r_first    <= 1'b1;
                            r_state    <= RUN;
`ifdef CSIDH_TIMEOUT_EN
                            r_tmo      <= '0;
`endif
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The core is still coming out of reset on the first RUN cycle; its done is not trusted.
                    r_first <= 1'b0;
                    if (!r_first && core_done) begin
                        r_res         <= core_A_out;
                        r_out_invalid <= core_invalid;
                        r_core_rst    <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_wcnt        <= '0;
                        r_state       <= DRAIN;
                    end
`ifdef CSIDH_TIMEOUT_EN
                    else if (r_tmo == 27'(TIMEOUT_CYCLES - 1)) begin
                        r_res         <= '0;
                        r_out_invalid <= 1'b1;
                        r_out_error   <= 1'b1;
                        r_core_rst    <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_wcnt        <= '0;
                        r_state       <= DRAIN;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (w_out_xfer) begin
                        if (w_last_o) begin
                            r_gnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_ptr       <= w_ptr_next;
                            r_wcnt      <= '0;
                            r_state     <= IDLE;
`ifdef CSIDH_TIMEOUT_EN
                            r_out_error <= 1'b0;
`endif
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign in_ready     = w_load ? r_gnt : '0;
    assign out_valid    = r_out_valid;
    // Word index only moves on a handshake, so out_data is stable under a stall.
    assign out_data     = r_res[int'(r_wcnt)*WORD_W +: WORD_W];
    assign out_last     = r_out_valid && w_last_o;
    assign out_id       = r_idx;
    assign out_invalid  = r_out_invalid;
    assign core_rst     = r_core_rst;
    assign core_A_in    = r_a;
    assign core_private = r_key;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_csidh_job_arbiter.sv
// Purpose : randomized self-checking bench for csidh_job_arbiter with a behavioural core and arbitration model.
// Latency : checks the one-cycle step from an accepted core_done to the first result word.
// Backpressure: exercises in_valid gaps and out_ready stalls, including the 1,0,0,1 ready pattern.
module tb_csidh_job_arbiter;

    localparam int NR = 2;
    localparam int N  = 512;
    localparam int KW = 296;
    localparam int WA = 8;
    localparam int WK = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req, gnt, in_valid, in_ready;
    logic [64*NR-1:0]  in_data;
    logic [63:0]       out_data;
    logic              out_valid, out_ready, out_last, out_invalid, out_error;
    logic [0:0]        out_id;
    logic              core_rst, core_done, core_invalid, busy;
    logic [N-1:0]      core_A_in, core_A_out;
    logic [KW-1:0]     core_private;

    always #5 clk = ~clk;

    csidh_job_arbiter #(
        .N       (N),
        .KEY_W   (KW),
        .NUM_REQ (NR)
`ifdef CSIDH_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (50)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .gnt          (gnt),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_last     (out_last),
        .out_invalid  (out_invalid),
        .out_error    (out_error),
        .core_rst     (core_rst),
        .core_A_in    (core_A_in),
        .core_private (core_private),
        .core_A_out   (core_A_out),
        .core_done    (core_done),
        .core_invalid (core_invalid),
        .busy         (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Core model state: done appears core_d RUN cycles after core_rst falls and stays until reset.
    int           run_cnt;
    int           core_d;
    bit           core_hang;
    bit           core_inv_m;
    logic [N-1:0] core_exp;

    // Arbitration model: outstanding requesters and the round-robin start index.
    logic [NR-1:0] pending;
    int            ptr_m;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (core_rst !== 1'b0) begin
            run_cnt      = 0;
            core_done    = 1'b0;
            core_A_out   = '0;
            core_invalid = 1'b0;
        end else begin
            run_cnt++;
            core_done    = !core_hang && (run_cnt >= core_d);
            // Garbage while leaving reset so a premature capture shows up in the result.
            core_A_out   = (run_cnt >= 2) ? core_exp : ~core_exp;
            core_invalid = (run_cnt >= 2) ? core_inv_m : ~core_inv_m;
        end
    endtask

    task automatic junk();
        in_valid = NR'($urandom);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic int pick(input logic [NR-1:0] p, input int ptr);
        for (int i = 0; i < NR; i++) begin
            if (p[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] rand_a();
        logic [N-1:0] a;
        for (int i = 0; i < N / 32; i++) a[32*i +: 32] = $urandom;
        return a;
    endfunction

    function automatic logic [64*WK-1:0] rand_k();
        logic [64*WK-1:0] k;
        for (int i = 0; i < 2 * WK; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // vmode: 0 random in_valid, 1 valid every other cycle, 2 always valid.
    // rmode: 0 random out_ready, 1 repeating 1,0,0,1, 2 always ready.
    task automatic serve(input logic [N-1:0] a_v, input logic [64*WK-1:0] k_v, input int d,
                         input bit inv, input bit hang, input int vmode, input int rmode,
                         input bit rst_mid);
        int           w, idx, guard, k;
        bit           v, rdy, xfer, inv_e, err_e;
        logic [N-1:0] res;
        logic [63:0]  words [WA+WK];

        w          = pick(pending, ptr_m);
        req        = pending;
        core_d     = d;
        core_hang  = hang;
        core_inv_m = inv;
        core_exp   = a_v + 1'b1;

        guard = 0;
        while (gnt == '0 && guard < 20) begin
            junk();
            tick();
            guard++;
        end
        chk("grant", gnt, NR'(1) << w);
        chk("out_id_grant", out_id, w);
        chk("busy_grant", busy, 1'b1);

        // The winner drops its request right away; the job must still complete.
        pending[w] = 1'b0;
        req        = pending;

        for (int i = 0; i < WA; i++) words[i] = a_v[64*i +: 64];
        for (int i = 0; i < WK; i++) words[WA+i] = k_v[64*i +: 64];

        idx   = 0;
        guard = 0;
        while (idx < WA + WK && guard < 200) begin
            junk();
            case (vmode)
                0:       v = ($urandom_range(0, 1) == 1);
                1:       v = ((guard % 2) == 0);
                default: v = 1'b1;
            endcase
            in_valid[w]          = v;
            in_data[64*w +: 64]  = words[idx];
            chk("in_ready_load", in_ready, NR'(1) << w);
            xfer = v && in_ready[w];
            tick();
            guard++;
            if (xfer) idx++;
        end
        chk("load_words", idx, WA + WK);
        junk();
        chk("core_rst_run", core_rst, 1'b0);
        chk("core_A_in", core_A_in, a_v);
        chk("core_private", core_private, k_v[KW-1:0]);
        chk("in_ready_run", in_ready, '0);

        if (rst_mid) begin
            repeat (3) begin
                junk();
                tick();
            end
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("rst_core_rst", core_rst, 1'b1);
            chk("rst_gnt", gnt, '0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_core_A_in", core_A_in, '0);
            ptr_m = 0;
            return;
        end

        guard = 0;
        while (!out_valid && guard < 300) begin
            bit elig;
            elig = core_done && (run_cnt >= 2);
            junk();
            tick();
            guard++;
            if (elig) begin
                chk("done_to_valid", out_valid, 1'b1);
                break;
            end
        end
        chk("drain_start", out_valid, 1'b1);
        chk("core_rst_drain", core_rst, 1'b1);

        if (hang) begin
            res   = '0;
            inv_e = 1'b1;
            err_e = 1'b1;
        end else begin
            res   = a_v + 1'b1;
            inv_e = inv;
            err_e = 1'b0;
        end

        k     = 0;
        guard = 0;
        while (k < WA && guard < 200) begin
            case (rmode)
                0:       rdy = ($urandom_range(0, 1) == 1);
                1:       rdy = ((guard % 4) == 0) || ((guard % 4) == 3);
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            chk("out_valid", out_valid, 1'b1);
            chk($sformatf("out_data[%0d]", k), out_data, res[64*k +: 64]);
            chk("out_last", out_last, (k == WA - 1));
            chk("out_invalid", out_invalid, inv_e);
            chk("out_error", out_error, err_e);
            chk("out_id_drain", out_id, w);
            junk();
            tick();
            guard++;
            if (rdy) k++;
        end
        out_ready = 1'b0;
        chk("drain_words", k, WA);
        chk("idle_gnt", gnt, '0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_out_valid", out_valid, 1'b0);
        chk("idle_out_error", out_error, 1'b0);
        ptr_m = (w + 1) % NR;
    endtask

    task automatic serve_rand();
        serve(rand_a(), rand_k(), $urandom_range(1, 30), ($urandom_range(0, 1) == 1), 1'b0,
              $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    endtask

    initial begin
        logic [N-1:0]     a_d;
        logic [64*WK-1:0] k_d;

        rst        = 1'b1;
        req        = '0;
        in_valid   = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        core_done  = 1'b0;
        core_A_out = '0;
        core_invalid = 1'b0;
        run_cnt    = 0;
        core_d     = 1;
        core_hang  = 1'b0;
        core_inv_m = 1'b0;
        core_exp   = '0;
        pending    = '0;
        ptr_m      = 0;

        repeat (2) tick();
        chk("rst_gnt", gnt, '0);
        chk("rst_in_ready", in_ready, '0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_invalid", out_invalid, 1'b0);
        chk("rst_out_error", out_error, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_id", out_id, '0);
        chk("rst_core_rst", core_rst, 1'b1);
        chk("rst_core_A_in", core_A_in, '0);
        chk("rst_core_private", core_private, '0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();

        // Single job with known words; result words 2,2,3..8.
        for (int i = 0; i < WA; i++) a_d[64*i +: 64] = 64'(i + 1);
        for (int i = 0; i < WK; i++) k_d[64*i +: 64] = 64'(10 + i);
        pending = 2'b01;
        serve(a_d, k_d, 100, 1'b0, 1'b0, 2, 2, 1'b0);

        // Contention after a fresh reset: 0 first, then 1, then 0 again.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ptr_m = 0;
        chk("rst_idle_busy", busy, 1'b0);
        pending = 2'b11;
        serve(rand_a(), rand_k(), 7, 1'b0, 1'b0, 1, 1, 1'b0);
        serve(rand_a(), rand_k(), 1, 1'b0, 1'b0, 1, 1, 1'b0);
        pending = 2'b11;
        serve(rand_a(), rand_k(), 12, 1'b0, 1'b0, 0, 1, 1'b0);

        // Invalid key, then a clean job that must see the flag cleared.
        pending = pending | 2'b01;
        serve(rand_a(), rand_k(), 20, 1'b1, 1'b0, 2, 0, 1'b0);
        pending = pending | 2'b01;
        serve(rand_a(), rand_k(), 1, 1'b0, 1'b0, 0, 2, 1'b0);

        // Reset in the middle of RUN: pointer must restart at 0.
        while (pending != '0) serve_rand();
        if (ptr_m == 0) begin
            pending = 2'b01;
            serve_rand();
        end
        pending = 2'b01;
        serve(rand_a(), rand_k(), 100, 1'b0, 1'b0, 2, 2, 1'b1);
        pending = 2'b11;
        serve_rand();

`ifdef CSIDH_TIMEOUT_EN
        while (pending != '0) serve_rand();
        pending = 2'b01;
        serve(rand_a(), rand_k(), 1, 1'b0, 1'b1, 2, 2, 1'b0);
`endif

        for (int j = 0; j < 16; j++) begin
            pending = pending | NR'($urandom);
            if (pending == '0) pending[$urandom_range(0, NR - 1)] = 1'b1;
            serve_rand();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

endmodule
